inst_fetch: RTL

Instruction fetch stage of the KGP-RISC pipeline, directly upstream of the instruction decoder. Holds the program counter, issues reads to a synchronous instruction memory with fixed one-cycle read latency, and buffers returned words in a 2-entry FIFO. Presents `{inst, pc}` to decode under a valid/ready handshake. Accepts branch/jump redirects that flush all buffered and in-flight fetches.

---
 rtl/inst_fetch_if.sv | 41 ++++
 rtl/inst_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Bundles the instruction-fetch stage's external buses: the instruction
// memory read port, the branch/jump redirect input and the valid/ready
// output channel to decode.
//
//   imem_en         fetch -> mem    read request this cycle
//   imem_addr       fetch -> mem    word address (ADDR_W bits)
//   imem_rdata      mem   -> fetch  read data, one cycle after imem_en
//   redirect_valid  pipe  -> fetch  branch/jump taken
//   redirect_pc     pipe  -> fetch  target byte address
//   out_valid       fetch -> decode head of buffer holds an instruction
//   out_ready       decode-> fetch  decode accepts the head
//   out_inst        fetch -> decode instruction word (0 when not valid)
//   out_pc          fetch -> decode byte address of out_inst (0 when not valid)
//
// master: the fetch stage view.  slave: the surrounding pipeline/memory view.
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [31:0]       out_pc;

   modport master (
      output imem_en, imem_addr, out_valid, out_inst, out_pc,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_inst, out_pc,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage of the KGP-RISC pipeline. Holds the PC, issues reads
// to a synchronous instruction memory with one-cycle latency, buffers returned
// words in a 2-entry FIFO and presents {inst, pc} to decode under valid/ready.
// A redirect flushes all buffered and in-flight fetches and reloads the PC.
//
// Parameters:
//   ADDR_W    instruction memory word-address width
//   RESET_PC  PC loaded on reset (bits [1:0] must be 0)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    inst_fetch_if.master (memory port, redirect, decode channel)
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_fetch_if.master  bus
);

   logic [31:0] pc_q,          pc_d;
   logic        req_pending_q, req_pending_d;
   logic [31:0] req_pc_q,      req_pc_d;
   logic [1:0]  count_q,       count_d;
   logic        rd_ptr_q,      rd_ptr_d;
   logic        wr_ptr_q,      wr_ptr_d;

   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_pc_q   [2];

   logic        out_valid;
   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occupancy;

   // Low address bits of the redirect target are forced to zero.
   logic        unused_redirect_lsb;
   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & bus.out_ready & ~bus.redirect_valid;
   assign push      = req_pending_q & ~bus.redirect_valid;

   // Slots that will be committed after this cycle: buffered words plus the
   // word already in flight, less the one leaving. Issuing only while this is
   // below 2 means every returned word finds a free slot.
   assign occupancy = {1'b0, count_q} + {2'b00, req_pending_q} - {2'b00, pop};

   // rst_n gates the request so the memory sees no read while reset is held.
   assign issue     = rst_n & ~bus.redirect_valid & (occupancy < 3'd2);

   assign bus.imem_en   = issue;
   assign bus.imem_addr = rst_n ? pc_q[ADDR_W+1:2] : '0;
   assign bus.out_valid = out_valid;
   assign bus.out_inst  = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
   assign bus.out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]   : '0;

   always_comb begin
      pc_d          = pc_q;
      req_pending_d = 1'b0;
      req_pc_d      = req_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;

      if (bus.redirect_valid) begin
         pc_d     = {bus.redirect_pc[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (issue) begin
            req_pc_d      = pc_q;
            pc_d          = pc_q + 32'd4;
            req_pending_d = 1'b1;
         end
         if (push) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         req_pending_q <= 1'b0;
         req_pc_q      <= '0;
         count_q       <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         req_pending_q <= req_pending_d;
         req_pc_q      <= req_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= bus.imem_rdata;
         fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

endmodule
